game_sequencer: RTL and testbench



---
 rtl/game_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - dino game flow controller: button debounce, IDLE/RUN/OVER FSM, speed ramp
//
// Purpose:
//   Owns the IDLE / RUN / OVER game state. The raw button is synchronised and
//   debounced into a single-cycle press pulse. The datapath is paced on the
//   renderer's frame tick, and scroll speed ramps up while the game runs.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn1         in   raw asynchronous button, 1 = pressed
//   frame_tick   in   one-cycle pulse per rendered frame
//   collision    in   dino/obstacle overlap level, sampled on frame_tick
//   gameon       out  high while in RUN
//   restart      out  one-cycle pulse on every entry to RUN
//   jump_req     out  one-cycle pulse per accepted press in RUN
//   scroll_step  out  obstacle pixels moved per frame
//   state        out  00 IDLE, 01 RUN, 10 OVER

module game_sequencer #(
    parameter int DEBOUNCE_CYCLES      = 270000,
    parameter int FRAMES_PER_SPEEDUP   = 200,
    parameter int MAX_SPEED            = 8,
    parameter int GAMEOVER_HOLD_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    input  logic       frame_tick,
    input  logic       collision,
    output logic       gameon,
    output logic       restart,
    output logic       jump_req,
    output logic [3:0] scroll_step,
    output logic [1:0] state
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (FRAMES_PER_SPEEDUP > 1) ? $clog2(FRAMES_PER_SPEEDUP) : 1;
    // hcnt must be able to hold the saturation value itself, not just values below it.
    localparam int HW = (GAMEOVER_HOLD_FRAMES > 0) ? $clog2(GAMEOVER_HOLD_FRAMES + 1) : 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_SPEEDUP - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(GAMEOVER_HOLD_FRAMES);
    localparam logic [3:0]    STEP_MAX  = 4'(MAX_SPEED);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic sync1_q;
    logic s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= btn1;
            s_q     <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: db follows s only after s has differed from it for
    // DEBOUNCE_CYCLES consecutive cycles. Any return to db restarts the count.
    // ------------------------------------------------------------------
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          db_q, db_d;
    logic          db_last_q;
    logic          press_q;

    always_comb begin
        dcnt_d = '0;
        db_d   = db_q;
        if (s_q != db_q) begin
            if (dcnt_q == DCNT_LAST) begin
                db_d   = s_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            db_q      <= 1'b0;
            db_last_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            db_q      <= db_d;
            db_last_q <= db_q;
            // Rising edge of the debounced level only; releases produce nothing.
            press_q   <= db_q & ~db_last_q;
        end
    end

    // ------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------
    state_e        state_q;
    logic          gameon_q;
    logic          restart_q;
    logic          jump_q;
    logic [3:0]    step_q;
    logic [FW-1:0] fcnt_q;
    logic [HW-1:0] hcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gameon_q  <= 1'b0;
            restart_q <= 1'b0;
            jump_q    <= 1'b0;
            step_q    <= 4'd1;
            fcnt_q    <= '0;
            hcnt_q    <= '0;
        end else begin
            restart_q <= 1'b0;
            jump_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press_q) begin
                        state_q   <= ST_RUN;
                        gameon_q  <= 1'b1;
                        restart_q <= 1'b1;
                        step_q    <= 4'd1;
                        fcnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_tick && collision) begin
                        // Collision wins over a same-cycle press: no jump is issued.
                        state_q  <= ST_OVER;
                        gameon_q <= 1'b0;
                        hcnt_q   <= '0;
                    end else begin
                        if (press_q) begin
                            jump_q <= 1'b1;
                        end
                        if (frame_tick) begin
                            if (fcnt_q == FCNT_LAST) begin
                                fcnt_q <= '0;
                                if (step_q < STEP_MAX) begin
                                    step_q <= step_q + 4'd1;
                                end
                            end else begin
                                fcnt_q <= fcnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (press_q && (hcnt_q == HOLD_DONE)) begin
                        state_q   <= ST_RUN;
                        gameon_q  <= 1'b1;
                        restart_q <= 1'b1;
                        step_q    <= 4'd1;
                        fcnt_q    <= '0;
                    end else if (frame_tick && (hcnt_q != HOLD_DONE)) begin
                        // Presses during the hold-off are simply dropped, never queued.
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    gameon_q <= 1'b0;
                end
            endcase
        end
    end

    assign gameon      = gameon_q;
    assign restart     = restart_q;
    assign jump_req    = jump_q;
    assign scroll_step = step_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer

module tb_game_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn1;
    logic       frame_tick;
    logic       collision;
    logic       gameon;
    logic       restart;
    logic       jump_req;
    logic [3:0] scroll_step;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(
        .DEBOUNCE_CYCLES      (4),
        .FRAMES_PER_SPEEDUP   (3),
        .MAX_SPEED            (3),
        .GAMEOVER_HOLD_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn1        (btn1),
        .frame_tick  (frame_tick),
        .collision   (collision),
        .gameon      (gameon),
        .restart     (restart),
        .jump_req    (jump_req),
        .scroll_step (scroll_step),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       ft;
        logic       col;
        logic [1:0] st;
        logic       go;
        logic       rs;
        logic       jp;
        logic [3:0] step;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic f, input logic c, input logic [1:0] st,
                       input logic go, input logic rs, input logic jp, input logic [3:0] step);
        vec_t v;
        v.btn = b; v.ft = f; v.col = c; v.st = st; v.go = go; v.rs = rs; v.jp = jp; v.step = step;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int st, input int go, input int rs,
                           input int jp, input int step);
        chk({name, "_state"}, int'(state), st);
        chk({name, "_gameon"}, int'(gameon), go);
        chk({name, "_restart"}, int'(restart), rs);
        chk({name, "_jump"}, int'(jump_req), jp);
        chk({name, "_step"}, int'(scroll_step), step);
    endtask

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic b, input logic f, input logic c);
        btn1 = b; frame_tick = f; collision = c;
        @(posedge clk);
        #1;
    endtask

    // Raise the button and hold it; the resulting pulse must land exactly on the 8th edge.
    task automatic press_expect(input string name, input bit want_rs, input bit want_jp,
                                input bit collide);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, collide && (i == 8), collide && (i == 8));
            chk({name, "_restart"}, int'(restart), (i == 8 && want_rs) ? 1 : 0);
            chk({name, "_jump"}, int'(jump_req), (i == 8 && want_jp) ? 1 : 0);
        end
    endtask

    initial begin
        int jcnt;
        int rcnt;

        rst_n = 1'b0; btn1 = 1'b0; frame_tick = 1'b0; collision = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk_all("reset", 0, 0, 0, 0, 1);

        // Start from IDLE, then a speed ramp with one tick per cycle.
        for (int i = 1; i <= 7; i++) add(1, 0, 0, 2'b00, 0, 0, 0, 1);
        add(1, 0, 0, 2'b01, 1, 1, 0, 1);
        add(1, 0, 0, 2'b01, 1, 0, 0, 1);
        add(0, 1, 0, 2'b01, 1, 0, 0, 1);
        add(0, 1, 0, 2'b01, 1, 0, 0, 1);
        add(0, 1, 0, 2'b01, 1, 0, 0, 2);
        add(0, 1, 0, 2'b01, 1, 0, 0, 2);
        add(0, 1, 0, 2'b01, 1, 0, 0, 2);
        add(0, 1, 0, 2'b01, 1, 0, 0, 3);
        add(0, 1, 0, 2'b01, 1, 0, 0, 3);
        add(0, 1, 0, 2'b01, 1, 0, 0, 3);
        add(0, 1, 0, 2'b01, 1, 0, 0, 3);

        foreach (tbl[i]) begin
            cyc(tbl[i].btn, tbl[i].ft, tbl[i].col);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].go, tbl[i].rs, tbl[i].jp, tbl[i].step);
        end

        // 3-cycle glitch must not produce a jump.
        jcnt = 0; rcnt = 0;
        repeat (3) begin
            cyc(1, 0, 0);
            jcnt += int'(jump_req);
        end
        repeat (12) begin
            cyc(0, 0, 0);
            jcnt += int'(jump_req);
            rcnt += int'(restart);
        end
        chk("glitch_jumps", jcnt, 0);
        chk("glitch_restarts", rcnt, 0);

        // Clean press: one jump on the 8th edge, none while held.
        press_expect("jump", 0, 1, 0);
        jcnt = 0;
        repeat (100) begin
            cyc(1, 0, 0);
            jcnt += int'(jump_req);
        end
        chk("hold_jumps", jcnt, 0);
        chk_all("after_hold", 1, 1, 0, 0, 3);
        repeat (10) cyc(0, 0, 0);

        // Press coincides with frame_tick+collision: collision wins.
        press_expect("collide", 0, 0, 1);
        chk_all("over", 2, 0, 0, 0, 3);
        repeat (10) cyc(0, 0, 0);
        chk_all("over_idle", 2, 0, 0, 0, 3);

        // Hold-off: one tick then press is ignored.
        cyc(0, 1, 0);
        press_expect("holdoff", 0, 0, 0);
        chk_all("holdoff_end", 2, 0, 0, 0, 3);
        repeat (10) cyc(0, 0, 0);

        // Second tick completes the hold-off; the next press restarts.
        cyc(0, 1, 0);
        press_expect("restart", 1, 0, 0);
        chk_all("restarted", 1, 1, 1, 0, 1);
        repeat (10) cyc(0, 0, 0);

        // Bring speed to 2, then reset asynchronously mid-cycle.
        repeat (3) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk_all("pre_reset", 1, 1, 0, 0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0);
        chk_all("post_reset", 0, 0, 0, 0, 1);
        press_expect("reset_restart", 1, 0, 0);
        chk_all("reset_run", 1, 1, 1, 0, 1);
        cyc(0, 0, 0);
        chk_all("reset_run2", 1, 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
